// File: rtl/cr_xp10_decomp_lz_be_pack.sv
// Byte packer between the LZ decoder and the decompressor back end.
// Collects 0..8 valid bytes per LZ beat into a 16-byte accumulator and emits
// dense 8-byte words. A per-frame output limit truncates the frame, drops the
// remaining input and flags the error on the frame's final word.
module cr_xp10_decomp_lz_be_pack #(
    parameter int DATA_W   = 64,
    parameter int BYTES_W  = 4,
    parameter int OLIMIT_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lz_in_valid,
    input  logic [DATA_W-1:0]   lz_in_data,
    input  logic [BYTES_W-1:0]  lz_in_bytes,
    input  logic                lz_in_last,
    output logic                lz_in_ready,
    output logic                pk_valid,
    output logic [DATA_W-1:0]   pk_data,
    output logic [BYTES_W-1:0]  pk_bytes,
    output logic                pk_last,
    output logic                pk_olimit_err,
    input  logic                pk_ready,
    input  logic [OLIMIT_W-1:0] cfg_olimit,
    output logic                olimit_event
);

    localparam int BEAT_B = DATA_W / 8;
    localparam int ACC_W  = 2 * DATA_W;
    localparam int BC_W   = OLIMIT_W + 1;
    localparam logic [BYTES_W-1:0] BEAT_CNT = BYTES_W'(BEAT_B);

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DROP  = 2'd2,
        TERM  = 2'd3
    } state_t;

    state_t             state_r, state_n_s;
    logic [ACC_W-1:0]   acc_r, acc_n_s;
    logic [BYTES_W-1:0] acc_cnt_r, acc_cnt_n_s;
    logic [BC_W-1:0]    byte_cnt_r, byte_cnt_n_s;
    logic               last_seen_r, last_seen_n_s;
    logic               final_sent_r, final_sent_n_s;

    logic [BYTES_W-1:0] beat_n_s, take_s, sh_s, rem_s, app_s;
    logic [BC_W-1:0]    sum_s, limit_s;
    logic [DATA_W-1:0]  beat_data_s;
    logic               load_s, final_s, over_s, beat_s, ready_s, xfer_last_s;
    logic               event_s;

    // Datapath: output-load decision, input acceptance, limit check, accumulator update.
    always_comb begin
        beat_n_s = (lz_in_bytes > BEAT_CNT) ? BEAT_CNT : lz_in_bytes;
        take_s   = (acc_cnt_r > BEAT_CNT) ? BEAT_CNT : acc_cnt_r;

        // In TERM the final word carries only the sub-word remainder; full
        // words still drain ahead of it.
        if (state_r == TERM) begin
            final_s = (acc_cnt_r < BEAT_CNT);
        end else begin
            final_s = last_seen_r && (acc_cnt_r <= BEAT_CNT);
        end

        // final_sent_r lets a frame end with an empty final word exactly once.
        load_s = (!pk_valid || pk_ready) &&
                 ((acc_cnt_r >= BEAT_CNT) ||
                  ((last_seen_r || (state_r == TERM)) && !final_sent_r));
        sh_s   = load_s ? take_s : {BYTES_W{1'b0}};
        rem_s  = acc_cnt_r - sh_s;

        // Readiness looks at the count left after this cycle's drain, which
        // keeps full-rate 8-byte beats flowing back to back.
        if (state_r == DROP) begin
            ready_s = 1'b1;
        end else if (state_r == PACK) begin
            ready_s = (rem_s < BEAT_CNT);
        end else begin
            ready_s = 1'b0;
        end
        beat_s = lz_in_valid && ready_s;

        limit_s = {1'b0, cfg_olimit};
        sum_s   = byte_cnt_r + BC_W'(beat_n_s);
        over_s  = (cfg_olimit != {OLIMIT_W{1'b0}}) && (sum_s > limit_s);

        if (state_r != PACK) begin
            app_s = {BYTES_W{1'b0}};
        end else if (over_s) begin
            app_s = BYTES_W'(limit_s - byte_cnt_r);
        end else begin
            app_s = beat_n_s;
        end

        for (int i = 0; i < BEAT_B; i++) begin
            beat_data_s[i*8 +: 8] = (i < int'(app_s)) ? lz_in_data[i*8 +: 8] : 8'd0;
        end

        acc_n_s = acc_r >> {sh_s, 3'b000};
        if (beat_s) begin
            acc_n_s     = acc_n_s | ({{DATA_W{1'b0}}, beat_data_s} << {rem_s, 3'b000});
            acc_cnt_n_s = rem_s + app_s;
        end else begin
            acc_cnt_n_s = rem_s;
        end

        xfer_last_s = pk_valid && pk_ready && pk_last;
        event_s     = (state_r == PACK) && beat_s && over_s;
    end

    // Frame-level control: state, last-beat tracking and the per-frame byte count.
    always_comb begin
        state_n_s      = state_r;
        last_seen_n_s  = last_seen_r;
        byte_cnt_n_s   = byte_cnt_r;
        final_sent_n_s = final_sent_r || (load_s && final_s);
        case (state_r)
            PACK: begin
                if (beat_s && over_s) begin
                    byte_cnt_n_s = limit_s;
                    if (lz_in_last) begin
                        last_seen_n_s = 1'b1;
                        state_n_s     = TERM;
                    end else begin
                        state_n_s = DROP;
                    end
                end else if (beat_s) begin
                    byte_cnt_n_s = sum_s;
                    if (lz_in_last) begin
                        last_seen_n_s = 1'b1;
                        state_n_s     = FLUSH;
                    end else begin
                        state_n_s = PACK;
                    end
                end else begin
                    state_n_s = PACK;
                end
            end
            FLUSH, TERM: begin
                if (xfer_last_s) begin
                    last_seen_n_s  = 1'b0;
                    final_sent_n_s = 1'b0;
                    byte_cnt_n_s   = {BC_W{1'b0}};
                    state_n_s      = PACK;
                end else begin
                    state_n_s = state_r;
                end
            end
            DROP: begin
                if (beat_s && lz_in_last) begin
                    state_n_s = TERM;
                end else begin
                    state_n_s = DROP;
                end
            end
            default: begin
                state_n_s = PACK;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= PACK;
            acc_r        <= {ACC_W{1'b0}};
            acc_cnt_r    <= {BYTES_W{1'b0}};
            byte_cnt_r   <= {BC_W{1'b0}};
            last_seen_r  <= 1'b0;
            final_sent_r <= 1'b0;
            olimit_event <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            acc_r        <= acc_n_s;
            acc_cnt_r    <= acc_cnt_n_s;
            byte_cnt_r   <= byte_cnt_n_s;
            last_seen_r  <= last_seen_n_s;
            final_sent_r <= final_sent_n_s;
            olimit_event <= event_s;
        end
    end

    // Output word register: loads from the accumulator, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_valid      <= 1'b0;
            pk_data       <= {DATA_W{1'b0}};
            pk_bytes      <= {BYTES_W{1'b0}};
            pk_last       <= 1'b0;
            pk_olimit_err <= 1'b0;
        end else if (load_s) begin
            pk_valid      <= 1'b1;
            pk_data       <= acc_r[DATA_W-1:0];
            pk_bytes      <= take_s;
            pk_last       <= final_s;
            pk_olimit_err <= final_s && (state_r == TERM);
        end else if (pk_ready) begin
            pk_valid      <= 1'b0;
            pk_last       <= 1'b0;
            pk_olimit_err <= 1'b0;
        end
    end

    assign lz_in_ready = ready_s && !rst;

endmodule

// File: tb/tb_cr_xp10_decomp_lz_be_pack.sv
// Randomized self-checking bench for the LZ back-end byte packer. A frame-level
// model turns each frame's byte stream and limit into the expected word list.
module tb_cr_xp10_decomp_lz_be_pack;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  n;
        logic        last;
        logic        err;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lz_in_valid = 1'b0;
    logic [63:0] lz_in_data = 64'd0;
    logic [3:0]  lz_in_bytes = 4'd0;
    logic        lz_in_last = 1'b0;
    logic        lz_in_ready;
    logic        pk_valid;
    logic [63:0] pk_data;
    logic [3:0]  pk_bytes;
    logic        pk_last;
    logic        pk_olimit_err;
    logic        pk_ready = 1'b1;
    logic [23:0] cfg_olimit = 24'd0;
    logic        olimit_event;

    word_t       exp_q[$];
    logic [7:0]  st[$];
    int          sz_q[$];
    int          word_cyc[$];
    int          n_pass = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          ev_cnt = 0;
    int          exp_ev = 0;
    int          words_seen = 0;
    int          first_acc_cyc = 0;
    bit          rdy_rand = 1'b0;

    cr_xp10_decomp_lz_be_pack dut (
        .clk           (clk),
        .rst           (rst),
        .lz_in_valid   (lz_in_valid),
        .lz_in_data    (lz_in_data),
        .lz_in_bytes   (lz_in_bytes),
        .lz_in_last    (lz_in_last),
        .lz_in_ready   (lz_in_ready),
        .pk_valid      (pk_valid),
        .pk_data       (pk_data),
        .pk_bytes      (pk_bytes),
        .pk_last       (pk_last),
        .pk_olimit_err (pk_olimit_err),
        .pk_ready      (pk_ready),
        .cfg_olimit    (cfg_olimit),
        .olimit_event  (olimit_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic word_t mk_word(input int pos, input int k, input bit last, input bit err);
        word_t w;
        w.d = 64'd0;
        for (int i = 0; i < k; i++) w.d[i*8 +: 8] = st[pos + i];
        w.n = 4'(k);
        w.last = last;
        w.err = err;
        return w;
    endfunction

    // Back-end ready: always high, or a coin toss every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: stall stability, scoreboard compare, event counting.
    initial begin
        logic  stall;
        word_t held;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (olimit_event) ev_cnt++;
                if (stall) begin
                    check_val("hold_valid", 64'(pk_valid), 64'd1);
                    check_val("hold_data", pk_data, held.d);
                    check_val("hold_bytes", 64'(pk_bytes), 64'(held.n));
                    check_val("hold_last", 64'(pk_last), 64'(held.last));
                    check_val("hold_err", 64'(pk_olimit_err), 64'(held.err));
                end
                if (pk_valid && pk_ready) begin
                    word_cyc.push_back(cyc);
                    words_seen++;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_word", 64'(pk_bytes), 64'hFFFF);
                    end else begin
                        word_t e;
                        e = exp_q.pop_front();
                        check_val("word_data", pk_data, e.d);
                        check_val("word_bytes", 64'(pk_bytes), 64'(e.n));
                        check_val("word_last", 64'(pk_last), 64'(e.last));
                        check_val("word_err", 64'(pk_olimit_err), 64'(e.err));
                    end
                end
                stall = pk_valid && !pk_ready;
                held = '{pk_data, pk_bytes, pk_last, pk_olimit_err};
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input int n, input bit last, output int acc_c);
        int waited;
        waited = 0;
        lz_in_valid = 1'b1;
        lz_in_data = d;
        lz_in_bytes = 4'(n);
        lz_in_last = last;
        @(negedge clk);
        while (!lz_in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) check_val("beat_accept_timeout", 64'(lz_in_ready), 64'd1);
        acc_c = cyc;
        @(posedge clk);
        #1;
        lz_in_valid = 1'b0;
        lz_in_last = 1'b0;
    endtask

    // Model the frame in sz_q under limit lim, queue its words, then drive it.
    task automatic send_frame(input logic [23:0] lim, input int gap_max);
        logic [63:0] bd[$];
        logic [63:0] d;
        int t, l, pos, k, n, c;
        bit err;
        st.delete();
        cfg_olimit = lim;
        foreach (sz_q[b]) begin
            d = {$urandom, $urandom};
            bd.push_back(d);
            n = (sz_q[b] > 8) ? 8 : sz_q[b];
            for (int i = 0; i < n; i++) st.push_back(d[i*8 +: 8]);
        end
        t = st.size();
        err = (lim != 24'd0) && (t > int'(lim));
        l = err ? int'(lim) : t;
        pos = 0;
        if (err) begin
            exp_ev++;
            while (l - pos >= 8) begin
                exp_q.push_back(mk_word(pos, 8, 1'b0, 1'b0));
                pos += 8;
            end
            exp_q.push_back(mk_word(pos, l - pos, 1'b1, 1'b1));
        end else if (t == 0) begin
            exp_q.push_back(mk_word(0, 0, 1'b1, 1'b0));
        end else begin
            while (pos < t) begin
                k = (t - pos > 8) ? 8 : t - pos;
                exp_q.push_back(mk_word(pos, k, (pos + k) == t, 1'b0));
                pos += k;
            end
        end
        foreach (sz_q[b]) begin
            send_beat(bd[b], sz_q[b], b == sz_q.size() - 1, c);
            if (b == 0) first_acc_cyc = c;
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || pk_valid) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int base, ev_base, c, nb;
        #2;
        check_val("rst_pk_valid", 64'(pk_valid), 64'd0);
        check_val("rst_pk_data", pk_data, 64'd0);
        check_val("rst_pk_bytes", 64'(pk_bytes), 64'd0);
        check_val("rst_pk_last", 64'(pk_last), 64'd0);
        check_val("rst_pk_err", 64'(pk_olimit_err), 64'd0);
        check_val("rst_ready", 64'(lz_in_ready), 64'd0);
        check_val("rst_event", 64'(olimit_event), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Eight full beats at full rate.
        word_cyc.delete();
        sz_q = '{8, 8, 8, 8, 8, 8, 8, 8};
        send_frame(24'd0, 0);
        wait_drain();
        check_val("t1_words", 64'(word_cyc.size()), 64'd8);
        if (word_cyc.size() == 8) begin
            check_val("t1_latency", 64'(word_cyc[0] - first_acc_cyc), 64'd2);
            check_val("t1_rate", 64'(word_cyc[7] - word_cyc[0]), 64'd7);
        end

        // Odd-sized beats pack contiguously.
        base = words_seen;
        sz_q = '{3, 5, 7, 1, 2};
        send_frame(24'd0, 1);
        wait_drain();
        check_val("t2_words", 64'(words_seen - base), 64'd3);

        // Limit 20 over 40 bytes: truncation, error, one event.
        ev_base = ev_cnt;
        sz_q = '{8, 8, 8, 8, 8};
        send_frame(24'd20, 0);
        wait_drain();
        check_val("t3_event", 64'(ev_cnt - ev_base), 64'd1);

        // Exactly hitting the limit is not an error.
        ev_base = ev_cnt;
        sz_q = '{8, 8};
        send_frame(24'd16, 0);
        wait_drain();
        check_val("t4_event", 64'(ev_cnt - ev_base), 64'd0);

        // Empty frame, then a long frame with a random back end.
        base = words_seen;
        sz_q = '{0};
        send_frame(24'd0, 0);
        wait_drain();
        check_val("t5_empty_words", 64'(words_seen - base), 64'd1);
        rdy_rand = 1'b1;
        sz_q.delete();
        for (int i = 0; i < 40; i++) sz_q.push_back($urandom_range(0, 12));
        sz_q.push_back($urandom_range(1, 8));
        send_frame(24'd0, 2);
        wait_drain();

        // Random frames with random limits and clamped byte counts.
        for (int f = 0; f < 25; f++) begin
            rdy_rand = 1'($urandom_range(0, 1));
            sz_q.delete();
            if ($urandom_range(0, 9) == 0) begin
                sz_q.push_back(0);
            end else begin
                nb = $urandom_range(0, 11);
                for (int i = 0; i < nb; i++) sz_q.push_back($urandom_range(0, 15));
                sz_q.push_back($urandom_range(1, 15));
            end
            send_frame(($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom_range(1, 80)), 1);
            wait_drain();
        end

        // Reset mid-frame with 5 bytes held, then a clean 8-byte frame.
        rdy_rand = 1'b0;
        cfg_olimit = 24'd0;
        send_beat({$urandom, $urandom}, 5, 1'b0, c);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", 64'(pk_valid), 64'd0);
        check_val("t6_rst_data", pk_data, 64'd0);
        check_val("t6_rst_bytes", 64'(pk_bytes), 64'd0);
        check_val("t6_rst_last", 64'(pk_last), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = words_seen;
        sz_q = '{8};
        send_frame(24'd0, 0);
        wait_drain();
        check_val("t6_words", 64'(words_seen - base), 64'd1);

        check_val("event_total", 64'(ev_cnt), 64'(exp_ev));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
